// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address: receives write bytes, supplies read bytes.
// SCL/SDA are oversampled on clk and SDA is driven open-drain (low or released).
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WR_BYTE   = 3'd3,
    S_WR_ACK    = 3'd4,
    S_RD_BYTE   = 3'd5,
    S_RD_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]             sreg, sreg_nxt;
  logic [7:0]             shift_byte;
  logic                   addr_match;
  logic [2:0]             bit_cnt, bit_cnt_nxt;
  logic                   byte_done, byte_done_nxt;
  logic                   sda_low, sda_low_nxt;
  logic [7:0]             rx_data_nxt;
  logic                   rx_valid_nxt, tx_req_nxt, addr_hit_nxt;
  logic                   rw_nxt, busy_nxt, stop_det_nxt;

  // Input synchronizers plus one history flop; idle bus level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_ev   = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_ev    = scl_s & scl_d & ~sda_d & sda_s;
  assign shift_byte = {sreg[6:0], sda_s};
  assign addr_match = (shift_byte[7:1] == ADDR);
  assign sda        = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop_ev) begin
      state_nxt = S_IDLE;
    end else if (start_ev) begin
      state_nxt = S_ADDR;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise && bit_cnt == 3'd0 && !addr_match) state_nxt = S_WAIT_STOP;
          else if (scl_fall && byte_done)                 state_nxt = S_ADDR_ACK;
        end
        S_ADDR_ACK: if (scl_fall) state_nxt = rw ? S_RD_BYTE : S_WR_BYTE;
        S_WR_BYTE:  if (scl_fall && byte_done) state_nxt = S_WR_ACK;
        S_WR_ACK:   if (scl_fall) state_nxt = S_WR_BYTE;
        S_RD_BYTE:  if (scl_fall && byte_done) state_nxt = S_RD_ACK;
        S_RD_ACK: begin
          if (scl_rise && sda_s) state_nxt = S_WAIT_STOP;
          else if (scl_fall)     state_nxt = S_RD_BYTE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    sreg_nxt      = sreg;
    bit_cnt_nxt   = bit_cnt;
    byte_done_nxt = byte_done;
    sda_low_nxt   = sda_low;
    rx_data_nxt   = rx_data;
    rw_nxt        = rw;
    busy_nxt      = busy;
    rx_valid_nxt  = 1'b0;
    tx_req_nxt    = 1'b0;
    addr_hit_nxt  = 1'b0;
    stop_det_nxt  = 1'b0;
    if (stop_ev) begin
      stop_det_nxt  = 1'b1;
      sda_low_nxt   = 1'b0;
      busy_nxt      = 1'b0;
      byte_done_nxt = 1'b0;
    end else if (start_ev) begin
      bit_cnt_nxt   = 3'd7;
      sda_low_nxt   = 1'b0;
      byte_done_nxt = 1'b0;
    end else begin
      case (state)
        // Byte phases shift on every rise; reads shift too so sreg[7] is always the next bit out.
        S_ADDR, S_WR_BYTE, S_RD_BYTE: begin
          if (scl_rise) begin
            sreg_nxt    = shift_byte;
            bit_cnt_nxt = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              byte_done_nxt = 1'b1;
              if (state == S_ADDR) begin
                if (addr_match) begin
                  rw_nxt = sda_s;
                end else begin
                  busy_nxt      = 1'b0;
                  byte_done_nxt = 1'b0;
                end
              end else if (state == S_WR_BYTE) begin
                rx_data_nxt  = shift_byte;
                rx_valid_nxt = 1'b1;
              end
            end
          end else if (scl_fall) begin
            if (state == S_RD_BYTE) sda_low_nxt = byte_done ? 1'b0 : ~sreg[7];
            else if (byte_done)     sda_low_nxt = 1'b1;
            byte_done_nxt = 1'b0;
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise) begin
            addr_hit_nxt = 1'b1;
            busy_nxt     = 1'b1;
            tx_req_nxt   = rw;
          end else if (scl_fall) begin
            if (rw) begin
              sreg_nxt    = tx_data;
              sda_low_nxt = ~tx_data[7];
            end else begin
              sda_low_nxt = 1'b0;
            end
          end
        end
        S_WR_ACK: if (scl_fall) sda_low_nxt = 1'b0;
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) busy_nxt = 1'b0;
            else       tx_req_nxt = 1'b1;
          end else if (scl_fall) begin
            sreg_nxt    = tx_data;
            sda_low_nxt = ~tx_data[7];
          end
        end
        default: sda_low_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= 3'd7;
      byte_done <= 1'b0;
      sda_low   <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      addr_hit  <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      byte_done <= byte_done_nxt;
      sda_low   <= sda_low_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_req    <= tx_req_nxt;
      addr_hit  <= addr_hit_nxt;
      rw        <= rw_nxt;
      busy      <= busy_nxt;
      stop_det  <= stop_det_nxt;
    end
  end

  always_ff @(posedge clk) begin
    sreg <= sreg_nxt;
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a behavioural I2C master drives the bus,
// with expected received/read bytes queued as stimulus is issued.
`timescale 1ns/1ps
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_hit, rw, busy, stop_det;
  wire        sda;

  int total = 0;
  int bad = 0;
  int n_hit = 0, n_txreq = 0, n_rx = 0, n_stop = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_q[$];

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (scl_m),
    .sda      (sda),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .addr_hit (addr_hit),
    .rw       (rw),
    .busy     (busy),
    .stop_det (stop_det)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on rx_valid and feeds tx_data on tx_req.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) begin
        n_rx++;
        chk("rx_expected", 32'(exp_rx.size() != 0), 1);
        if (exp_rx.size() != 0) chk("rx_data", rx_data, exp_rx.pop_front());
      end
      if (addr_hit) n_hit++;
      if (stop_det) n_stop++;
      if (tx_req) begin
        n_txreq++;
        if (tx_q.size() != 0) tx_data = tx_q.pop_front();
      end
    end
  end

  task automatic qw();
    repeat (5) @(negedge clk);
  endtask

  task automatic clr();
    n_hit = 0; n_txreq = 0; n_rx = 0; n_stop = 0;
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; qw();
    scl_m = 1'b1;     qw();
    m_sda_low = 1'b1; qw();
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    qw(); m_sda_low = 1'b1;
    qw(); scl_m = 1'b1;
    qw(); m_sda_low = 1'b0;
    qw();
  endtask

  task automatic put_bit(input logic b, output logic seen);
    qw(); m_sda_low = ~b;
    qw(); scl_m = 1'b1;
    qw(); seen = sda;
    qw(); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i], b);
    put_bit(1'b1, ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, b);
      d[i] = b;
    end
    put_bit(nack, b);
    chk("rd_expected", 32'(exp_rd.size() != 0), 1);
    if (exp_rd.size() != 0) chk("rd_byte", d, exp_rd.pop_front());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    logic [7:0] d;
    int         k;
    logic [7:0] wr_bytes [4];
    wr_bytes = '{8'h00, 8'hFF, 8'h5A, 8'h81};

    repeat (3) @(negedge clk);
    chk("rst_sda", sda, 1'b1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_addr_hit", addr_hit, 0);
    chk("rst_rw", rw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stop_det", stop_det, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single-byte write
    clr();
    bus_start();
    write_byte(8'h84, a); chk("t1_addr_ack", a, 0);
    chk("t1_rw", rw, 0);
    chk("t1_busy", busy, 1);
    exp_rx.push_back(8'hA5);
    write_byte(8'hA5, a); chk("t1_data_ack", a, 0);
    bus_stop(); repeat (5) @(negedge clk);
    chk("t1_hits", n_hit, 1);
    chk("t1_rx_cnt", n_rx, 1);
    chk("t1_stops", n_stop, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_sda_end", sda, 1'b1);

    // Address mismatch
    clr();
    bus_start();
    write_byte(8'h86, a); chk("t2_addr_nack", a, 1);
    write_byte(8'h55, a); chk("t2_data_nack", a, 1);
    bus_stop(); repeat (5) @(negedge clk);
    chk("t2_hits", n_hit, 0);
    chk("t2_rx_cnt", n_rx, 0);
    chk("t2_stops", n_stop, 1);
    chk("t2_busy", busy, 0);
    chk("t2_rx_kept", rx_data, 8'hA5);

    // Two-byte read, NACK on the last
    clr();
    tx_q.push_back(8'h3C); tx_q.push_back(8'hC3);
    exp_rd.push_back(8'h3C); exp_rd.push_back(8'hC3);
    bus_start();
    write_byte(8'h85, a); chk("t3_addr_ack", a, 0);
    chk("t3_rw", rw, 1);
    read_byte(1'b0, d);
    read_byte(1'b1, d);
    qw();
    chk("t3_busy_after_nack", busy, 0);
    chk("t3_sda_released", sda, 1'b1);
    bus_stop(); repeat (5) @(negedge clk);
    chk("t3_txreq", n_txreq, 2);
    chk("t3_hits", n_hit, 1);
    chk("t3_stops", n_stop, 1);

    // Write then repeated start into a read
    clr();
    bus_start();
    write_byte(8'h84, a); chk("t4_waddr_ack", a, 0);
    exp_rx.push_back(8'h01);
    write_byte(8'h01, a); chk("t4_wdata_ack", a, 0);
    chk("t4_rw_write", rw, 0);
    tx_q.push_back(8'h7E); exp_rd.push_back(8'h7E);
    bus_start();
    write_byte(8'h85, a); chk("t4_raddr_ack", a, 0);
    chk("t4_rw_read", rw, 1);
    read_byte(1'b1, d);
    bus_stop(); repeat (5) @(negedge clk);
    chk("t4_rx_data", rx_data, 8'h01);
    chk("t4_hits", n_hit, 2);
    chk("t4_rx_cnt", n_rx, 1);
    chk("t4_txreq", n_txreq, 1);

    // Four-byte write
    clr();
    bus_start();
    write_byte(8'h84, a); chk("t5_addr_ack", a, 0);
    for (int i = 0; i < 4; i++) begin
      exp_rx.push_back(wr_bytes[i]);
      write_byte(wr_bytes[i], a); chk("t5_data_ack", a, 0);
    end
    bus_stop(); repeat (5) @(negedge clk);
    chk("t5_rx_cnt", n_rx, 4);
    chk("t5_rx_last", rx_data, 8'h81);
    chk("t5_hits", n_hit, 1);

    // Reset while the slave drives a 0 data bit
    tx_q.push_back(8'h00);
    bus_start();
    write_byte(8'h85, a); chk("t6_addr_ack", a, 0);
    k = 0;
    while (sda !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t6_slave_low", sda, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_sda", sda, 1'b1);
    chk("t6_rst_rx_data", rx_data, 8'h00);
    chk("t6_rst_rw", rw, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pulses", {28'd0, rx_valid, tx_req, addr_hit, stop_det}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    clr();
    tx_q.push_back(8'h96); exp_rd.push_back(8'h96);
    bus_start();
    write_byte(8'h85, a); chk("t6_post_addr_ack", a, 0);
    read_byte(1'b1, d);
    bus_stop(); repeat (5) @(negedge clk);
    chk("t6_post_hits", n_hit, 1);
    chk("t6_post_txreq", n_txreq, 1);
    chk("t6_post_stops", n_stop, 1);

    chk("end_exp_rx_empty", exp_rx.size(), 0);
    chk("end_exp_rd_empty", exp_rd.size(), 0);
    chk("end_tx_q_empty", tx_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
